// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cache_pkg
//  Purpose  : Shared geometry constants and FSM state encoding for the
//             direct-mapped write-through data cache.
//  Contents : TAG_W/IDX_W/OFF_W address split, LINES/WORDS geometry,
//             state_e FSM encoding, word_index() helper.
//  Revision : 1.0  initial release
// ============================================================================
package cache_pkg;

   localparam int TAG_W       = 3;
   localparam int IDX_W       = 5;
   localparam int OFF_W       = 2;
   localparam int LINES       = 32;
   localparam int WORDS       = 4;
   localparam int WORD_ADDR_W = IDX_W + OFF_W;

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_REFILL    = 2'd1,
      S_WRITE_MEM = 2'd2
   } state_e;

   // Flat word address inside the data array for a given line and word.
   function automatic logic [WORD_ADDR_W-1:0] word_index(
      input logic [IDX_W-1:0] idx,
      input logic [OFF_W-1:0] off
   );
      return {idx, off};
   endfunction

endpackage
`default_nettype wire

// File: rtl/cache_data_array.sv
`default_nettype none
// ============================================================================
//  Module   : cache_data_array
//  Purpose  : Word storage for the data cache (LINES x WORDS words).
//  Ports    : clk       - clock
//             we_i      - word write enable (one word per cycle)
//             waddr_i   - word address to write
//             wdata_i   - write data
//             raddr_i   - word address to read (combinational)
//             rdata_o   - read data
//  Revision : 1.0  initial release
// ============================================================================
module cache_data_array #(
   parameter int DATA_W = 32,
   parameter int AW     = 7,
   parameter int DEPTH  = 128
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [AW-1:0]     waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [AW-1:0]     raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/dcache_controller.sv
`default_nettype none
// ============================================================================
//  Module   : dcache_controller
//  Purpose  : Direct-mapped, write-through, no-write-allocate data cache
//             controller (32 lines x 4 words) with a stall-based core
//             interface and a simple request/ready main-memory interface.
//  Ports    : clk, rst (sync, active-low)
//             MemRead, MemWrite, addr, wdata  - core request
//             rdata, stall                    - core response
//             mem_rd_en, mem_wr_en, mem_addr,
//             mem_wdata                       - memory request
//             mem_rdata, mem_ready            - memory response
//  Revision : 1.0  initial release
// ============================================================================
module dcache_controller
   import cache_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              stall,
   output logic              mem_rd_en,
   output logic              mem_wr_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready
);

   // ------------------------------------------------------------------------
   // Address fields of the live request and of the captured store
   // ------------------------------------------------------------------------
   logic [TAG_W-1:0] req_tag;
   logic [IDX_W-1:0] req_idx;
   logic [OFF_W-1:0] req_off;

   logic [ADDR_W-1:0] cap_addr_q;
   logic [DATA_W-1:0] cap_wdata_q;
   logic [TAG_W-1:0]  cap_tag;
   logic [IDX_W-1:0]  cap_idx;
   logic [OFF_W-1:0]  cap_off;

   assign req_tag = addr[OFF_W+IDX_W +: TAG_W];
   assign req_idx = addr[OFF_W +: IDX_W];
   assign req_off = addr[0 +: OFF_W];

   assign cap_tag = cap_addr_q[OFF_W+IDX_W +: TAG_W];
   assign cap_idx = cap_addr_q[OFF_W +: IDX_W];
   assign cap_off = cap_addr_q[0 +: OFF_W];

   // ------------------------------------------------------------------------
   // State, tag and valid storage
   // ------------------------------------------------------------------------
   state_e           state_q;
   logic [OFF_W-1:0] cnt_q;
   logic [LINES-1:0] valid_q;
   logic [TAG_W-1:0] tag_q [LINES];
   logic             rd_en_q;
   logic             wr_en_q;

   logic hit;
   logic cap_hit;
   logic last_beat;

   assign hit       = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
   assign cap_hit   = valid_q[cap_idx] && (tag_q[cap_idx] == cap_tag);
   assign last_beat = (cnt_q == OFF_W'(WORDS - 1));

   // ------------------------------------------------------------------------
   // Data array write port: refill beats or a store that hits
   // ------------------------------------------------------------------------
   logic                   arr_we;
   logic [WORD_ADDR_W-1:0] arr_waddr;
   logic [DATA_W-1:0]      arr_wdata;
   logic [DATA_W-1:0]      arr_rdata;

   always_comb begin
      arr_we    = 1'b0;
      arr_waddr = word_index(req_idx, cnt_q);
      arr_wdata = mem_rdata;
      case (state_q)
         S_REFILL: begin
            arr_we = mem_ready;
         end
         S_WRITE_MEM: begin
            // Write-through, no-write-allocate: only update a resident line.
            arr_we    = mem_ready && cap_hit;
            arr_waddr = word_index(cap_idx, cap_off);
            arr_wdata = cap_wdata_q;
         end
         default: begin
            arr_we = 1'b0;
         end
      endcase
   end

   cache_data_array #(
      .DATA_W (DATA_W),
      .AW     (WORD_ADDR_W),
      .DEPTH  (LINES * WORDS)
   ) u_data_array (
      .clk     (clk),
      .we_i    (arr_we),
      .waddr_i (arr_waddr),
      .wdata_i (arr_wdata),
      .raddr_i (word_index(req_idx, req_off)),
      .rdata_o (arr_rdata)
   );

   // ------------------------------------------------------------------------
   // Control FSM. Memory enables are registered alongside the state so they
   // are glitch-free and mutually exclusive by construction.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         valid_q <= '0;
         rd_en_q <= 1'b0;
         wr_en_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               // A simultaneous read and write is served as a write.
               if (MemWrite) begin
                  state_q <= S_WRITE_MEM;
                  wr_en_q <= 1'b1;
               end else if (MemRead && !hit) begin
                  state_q <= S_REFILL;
                  rd_en_q <= 1'b1;
                  cnt_q   <= '0;
               end
            end
            S_REFILL: begin
               if (mem_ready) begin
                  cnt_q <= cnt_q + OFF_W'(1);
                  if (last_beat) begin
                     // Line becomes valid only once every word has arrived.
                     valid_q[req_idx] <= 1'b1;
                     state_q          <= S_IDLE;
                     rd_en_q          <= 1'b0;
                  end
               end
            end
            S_WRITE_MEM: begin
               if (mem_ready) begin
                  state_q <= S_IDLE;
                  wr_en_q <= 1'b0;
               end
            end
            default: begin
               state_q <= S_IDLE;
               rd_en_q <= 1'b0;
               wr_en_q <= 1'b0;
            end
         endcase
      end
   end

   // Tag array and store capture registers carry no reset: their contents
   // are qualified by valid_q and by the FSM state respectively.
   always_ff @(posedge clk) begin
      if (state_q == S_REFILL && mem_ready && last_beat) begin
         tag_q[req_idx] <= req_tag;
      end
   end

   always_ff @(posedge clk) begin
      if (state_q == S_IDLE && MemWrite) begin
         cap_addr_q  <= addr;
         cap_wdata_q <= wdata;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   always_comb begin
      stall = 1'b0;
      case (state_q)
         S_IDLE:      stall = MemWrite || (MemRead && !hit);
         S_REFILL:    stall = 1'b1;
         S_WRITE_MEM: stall = !mem_ready;
         default:     stall = 1'b0;
      endcase
   end

   always_comb begin
      mem_addr = '0;
      case (state_q)
         S_REFILL:    mem_addr = {addr[ADDR_W-1:OFF_W], cnt_q};
         S_WRITE_MEM: mem_addr = cap_addr_q;
         default:     mem_addr = '0;
      endcase
   end

   assign mem_rd_en = rd_en_q;
   assign mem_wr_en = wr_en_q;
   assign mem_wdata = cap_wdata_q;
   assign rdata     = arr_rdata;

endmodule
`default_nettype wire

// File: tb/tb_dcache_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dcache_controller
//  Purpose  : Self-checking bench for dcache_controller. Directed stimulus
//             pushes expected load data and memory transactions into queues;
//             a monitor pops and compares whenever the DUT presents them.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dcache_controller;

   logic        clk;
   logic        rst;
   logic        MemRead;
   logic        MemWrite;
   logic [9:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        stall;
   logic        mem_rd_en;
   logic        mem_wr_en;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ready;

   int checks = 0;
   int errors = 0;

   logic [31:0] tbmem [1024];
   logic        spurious;
   int          wr_wait;

   logic [9:0]  exp_rd_addr_q [$];
   logic [31:0] exp_rdata_q   [$];
   logic [41:0] exp_wr_q      [$];

   logic [9:0]  mon_ea;
   logic [31:0] mon_ed;
   logic [41:0] mon_ew;

   dcache_controller #(
      .ADDR_W (10),
      .DATA_W (32)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .MemRead   (MemRead),
      .MemWrite  (MemWrite),
      .addr      (addr),
      .wdata     (wdata),
      .rdata     (rdata),
      .stall     (stall),
      .mem_rd_en (mem_rd_en),
      .mem_wr_en (mem_wr_en),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Main memory model: read beats every cycle, write acknowledged on the
   // third cycle of mem_wr_en; optional spurious ready while idle.
   initial begin
      for (int i = 0; i < 1024; i++) tbmem[i] = 32'h5000_0000 + 32'(i);
      tbmem[10'h084] = 32'h0000_00A0;
      tbmem[10'h085] = 32'h0000_00A1;
      tbmem[10'h086] = 32'h0000_00A2;
      tbmem[10'h087] = 32'h0000_00A3;
      mem_ready = 1'b0;
      mem_rdata = '0;
      wr_wait   = 0;
      forever begin
         @(posedge clk);
         #2;
         mem_ready = 1'b0;
         if (mem_rd_en) begin
            mem_ready = 1'b1;
            mem_rdata = tbmem[mem_addr];
            wr_wait   = 0;
         end else if (mem_wr_en) begin
            wr_wait++;
            if (wr_wait == 3) begin
               mem_ready        = 1'b1;
               tbmem[mem_addr]  = mem_wdata;
               wr_wait          = 0;
            end
         end else begin
            wr_wait   = 0;
            mem_ready = spurious;
         end
      end
   end

   // Scoreboard monitor
   always @(negedge clk) begin
      check("en_excl", {31'b0, mem_rd_en & mem_wr_en}, 32'd0);
      if (mem_rd_en && mem_ready) begin
         if (exp_rd_addr_q.size() == 0) begin
            check("rd_beat_unexpected", {22'b0, mem_addr}, 32'hFFFF_FFFF);
         end else begin
            mon_ea = exp_rd_addr_q.pop_front();
            check("rd_beat_addr", {22'b0, mem_addr}, {22'b0, mon_ea});
         end
      end
      if (mem_wr_en && mem_ready) begin
         if (exp_wr_q.size() == 0) begin
            check("wr_unexpected", {22'b0, mem_addr}, 32'hFFFF_FFFF);
         end else begin
            mon_ew = exp_wr_q.pop_front();
            check("wr_addr", {22'b0, mem_addr}, {22'b0, mon_ew[41:32]});
            check("wr_data", mem_wdata, mon_ew[31:0]);
         end
      end
      if (MemRead && !MemWrite && !stall) begin
         if (exp_rdata_q.size() == 0) begin
            check("rdata_unexpected", rdata, 32'hFFFF_FFFF);
         end else begin
            mon_ed = exp_rdata_q.pop_front();
            check("rdata", rdata, mon_ed);
         end
      end
   end

   task automatic do_read(input logic [9:0] a, input logic [31:0] exp, input bit miss);
      int stalls;
      int beats;
      exp_rdata_q.push_back(exp);
      if (miss) for (int i = 0; i < 4; i++) exp_rd_addr_q.push_back({a[9:2], 2'(i)});
      @(posedge clk); #1;
      MemRead = 1'b1;
      addr    = a;
      stalls  = 0;
      beats   = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (mem_rd_en) beats++;
         if (!stall) break;
         stalls++;
      end
      check("rd_stall_cycles", 32'(stalls), miss ? 32'd5 : 32'd0);
      check("rd_beats", 32'(beats), miss ? 32'd4 : 32'd0);
      @(posedge clk); #1;
      MemRead = 1'b0;
   endtask

   task automatic do_write(input logic [9:0] a, input logic [31:0] d, input bit both);
      int stalls;
      int wrs;
      exp_wr_q.push_back({a, d});
      @(posedge clk); #1;
      MemWrite = 1'b1;
      MemRead  = both;
      addr     = a;
      wdata    = d;
      stalls   = 0;
      wrs      = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (mem_wr_en) wrs++;
         if (!stall) break;
         stalls++;
      end
      check("wr_stall_cycles", 32'(stalls), 32'd3);
      check("wr_en_cycles", 32'(wrs), 32'd3);
      @(posedge clk); #1;
      MemWrite = 1'b0;
      MemRead  = 1'b0;
   endtask

   initial begin
      rst      = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      addr     = '0;
      wdata    = '0;
      spurious = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_stall", {31'b0, stall}, 32'd0);
      check("reset_rd_en", {31'b0, mem_rd_en}, 32'd0);
      check("reset_wr_en", {31'b0, mem_wr_en}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;

      // Idle, no request
      @(negedge clk);
      check("idle_stall", {31'b0, stall}, 32'd0);

      // Cold read miss, then hit in the same line
      do_read(10'h084, 32'h0000_00A0, 1'b1);
      do_read(10'h085, 32'h0000_00A1, 1'b0);

      // Write hit, then read back
      do_write(10'h086, 32'hDEAD_BEEF, 1'b0);
      do_read(10'h086, 32'hDEAD_BEEF, 1'b0);

      // Spurious mem_ready while idle is ignored
      @(posedge clk); #1;
      spurious = 1'b1;
      @(negedge clk);
      check("spur_stall", {31'b0, stall}, 32'd0);
      check("spur_rd_en", {31'b0, mem_rd_en}, 32'd0);
      @(posedge clk); #1;
      spurious = 1'b0;
      @(negedge clk);
      check("spur_rd_en_after", {31'b0, mem_rd_en}, 32'd0);
      check("spur_wr_en_after", {31'b0, mem_wr_en}, 32'd0);
      do_read(10'h085, 32'h0000_00A1, 1'b0);

      // Write miss does not allocate
      do_write(10'h3FC, 32'hCAFE_0001, 1'b0);
      do_read(10'h3FC, 32'hCAFE_0001, 1'b1);

      // Read and write together behave as a write
      do_write(10'h087, 32'h1234_5678, 1'b1);
      do_read(10'h087, 32'h1234_5678, 1'b0);

      // Conflict eviction on index 1
      do_read(10'h184, 32'h5000_0184, 1'b1);
      do_read(10'h084, 32'h0000_00A0, 1'b1);
      do_read(10'h087, 32'h1234_5678, 1'b0);

      // Reset during the second refill beat
      exp_rd_addr_q.push_back(10'h200);
      exp_rd_addr_q.push_back(10'h201);
      @(posedge clk); #1;
      MemRead = 1'b1;
      addr    = 10'h200;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      rst     = 1'b1;
      MemRead = 1'b0;
      @(negedge clk);
      check("abort_rd_en", {31'b0, mem_rd_en}, 32'd0);
      check("abort_stall", {31'b0, stall}, 32'd0);
      do_read(10'h200, 32'h5000_0200, 1'b1);
      do_read(10'h084, 32'h0000_00A0, 1'b1);

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rdq_empty", 32'(exp_rdata_q.size()), 32'd0);
      check("rdaddrq_empty", 32'(exp_rd_addr_q.size()), 32'd0);
      check("wrq_empty", 32'(exp_wr_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
